// File: rtl/sha256_golden_nonce_checker.sv
// Golden-nonce filter behind the last sha256_transform: byte-reorders each hash, compares it
// against the job target and queues winning nonces. Latency 2 cycles to gn_valid; full FIFO drops and flags overflow.

// Generic FIFO: registered output, no bypass, push accepted when not full or popping.
module sha256_gn_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         push_rdy_o,
    output logic         pop_vld_o,
    input  logic         pop_rdy_i,
    output logic [W-1:0] pop_dat_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          push;
    logic          pop;

    assign pop_vld_o  = (cnt_q != '0);
    assign pop        = pop_vld_o && pop_rdy_i;
    assign push_rdy_o = (cnt_q != (AW+1)'(DEPTH)) || pop;
    assign push       = push_vld_i && push_rdy_o;
    assign pop_dat_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end
endmodule

module sha256_golden_nonce_checker #(
    parameter int unsigned NONCE_OFFSET = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work_load,
    input  logic [31:0]  nonce_start,
    input  logic [255:0] target,
    input  logic         hash_valid,
    input  logic [255:0] hash,
    output logic         gn_valid,
    input  logic         gn_ready,
    output logic [31:0]  gn_nonce,
    output logic [31:0]  hit_count,
    output logic         overflow
);
    logic [255:0] target_q;
    logic [31:0]  base_q;
    logic [31:0]  beat_q;
    logic [31:0]  beat_d;
    logic [255:0] target_eff;
    logic [31:0]  base_eff;
    logic [31:0]  beat_eff;

    logic         s1_vld_q;
    logic [255:0] s1_cmp_q;
    logic [255:0] s1_tgt_q;
    logic [31:0]  s1_nonce_q;

    logic [31:0]  hit_q;
    logic         ovf_q;
    logic         golden;
    logic         push_rdy;

    // H7 already sits in the top word, so numeric order is a byte swap of each word in place.
    function automatic logic [255:0] reorder(input logic [255:0] h);
        logic [255:0] r;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            w = h[32*i +: 32];
            r[32*i +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return r;
    endfunction

    // A beat arriving with work_load already belongs to the new job.
    always_comb begin
        target_eff = work_load ? target      : target_q;
        base_eff   = work_load ? nonce_start : base_q;
        beat_eff   = work_load ? 32'd0       : beat_q;
        beat_d     = hash_valid ? beat_eff + 32'd1 : beat_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            base_q     <= '0;
            beat_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_cmp_q   <= '0;
            s1_tgt_q   <= '0;
            s1_nonce_q <= '0;
        end else begin
            target_q   <= target_eff;
            base_q     <= base_eff;
            beat_q     <= beat_d;
            s1_vld_q   <= hash_valid;
            if (hash_valid) begin
                s1_cmp_q   <= reorder(hash);
                s1_tgt_q   <= target_eff;
                s1_nonce_q <= base_eff + beat_eff - 32'(NONCE_OFFSET);
            end
        end
    end

    // The target travels with the beat, so in-flight results ignore a later work_load.
    assign golden = s1_vld_q && (s1_cmp_q <= s1_tgt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            ovf_q <= 1'b0;
        end else if (golden) begin
            if (hit_q != 32'hFFFF_FFFF) begin
                hit_q <= hit_q + 32'd1;
            end
            if (!push_rdy) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sha256_gn_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (golden),
        .push_dat_i (s1_nonce_q),
        .push_rdy_o (push_rdy),
        .pop_vld_o  (gn_valid),
        .pop_rdy_i  (gn_ready),
        .pop_dat_o  (gn_nonce)
    );

    assign hit_count = hit_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_sha256_golden_nonce_checker.sv
// Two checkers (NONCE_OFFSET 0 and 3) share stimulus; a reference model predicts the
// golden-nonce queue, hit count and overflow, and a monitor compares on every cycle.
module tb_sha256_golden_nonce_checker;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         work_load = 1'b0;
    logic [31:0]  nonce_start = '0;
    logic [255:0] target = '0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash = '0;
    logic         gn_ready = 1'b0;
    logic         gv0, gv3, of0, of3;
    logic [31:0]  gn0, gn3, hc0, hc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_golden_nonce_checker #(.NONCE_OFFSET(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .work_load(work_load), .nonce_start(nonce_start),
        .target(target), .hash_valid(hash_valid), .hash(hash), .gn_valid(gv0),
        .gn_ready(gn_ready), .gn_nonce(gn0), .hit_count(hc0), .overflow(of0));

    sha256_golden_nonce_checker #(.NONCE_OFFSET(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .work_load(work_load), .nonce_start(nonce_start),
        .target(target), .hash_valid(hash_valid), .hash(hash), .gn_valid(gv3),
        .gn_ready(gn_ready), .gn_nonce(gn3), .hit_count(hc3), .overflow(of3));

    // Expected FIFO contents: {nonce for offset 0, nonce for offset 3}.
    logic [63:0]  exp_q[$];
    logic [255:0] m_tgt = '0;
    logic [31:0]  m_base = '0;
    logic [31:0]  m_beat = '0;
    logic [31:0]  m_hits = '0;
    logic         m_ovf = 1'b0;
    logic         p_vld = 1'b0;
    logic         p_gold = 1'b0;
    logic [63:0]  p_nonce = '0;

    localparam logic [255:0] T_EQ = {32'h0, {7{32'hFFFF_FFFF}}};
    localparam logic [255:0] T_ALL = {8{32'hFFFF_FFFF}};

    // Bitcoin numeric value: words taken from H7 down to H0, each read little-endian.
    function automatic logic [255:0] numeric_order(input logic [255:0] h);
        logic [255:0] acc;
        logic [31:0]  w;
        acc = '0;
        for (int k = 7; k >= 0; k--) begin
            w = h[k*32 +: 32];
            acc = {acc[223:0], w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return acc;
    endfunction

    function automatic logic [255:0] mk(input logic [31:0] h7, input logic [31:0] rest);
        return {h7, {7{rest}}};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a golden beat lands in the queue at the edge after it was presented.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            m_tgt = '0; m_base = '0; m_beat = '0; m_hits = '0; m_ovf = 1'b0;
            p_vld = 1'b0; p_gold = 1'b0; p_nonce = '0;
        end else begin
            if (p_vld && p_gold) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
                if (exp_q.size() < 4) exp_q.push_back(p_nonce);
                else m_ovf = 1'b1;
            end
            p_vld = hash_valid;
            if (work_load) begin
                m_tgt = target; m_base = nonce_start; m_beat = '0;
            end
            if (hash_valid) begin
                p_gold  = numeric_order(hash) <= m_tgt;
                p_nonce = {m_base + m_beat, m_base + m_beat - 32'd3};
                m_beat  = m_beat + 32'd1;
            end
        end
    end

    // Monitor: compares the presented head and status; a handshake retires the head.
    initial forever begin
        logic e;
        @(negedge clk);
        if (rst_n) begin
            e = (exp_q.size() != 0);
            chk("gn_valid0", {31'b0, gv0}, {31'b0, e});
            chk("gn_valid3", {31'b0, gv3}, {31'b0, e});
            if (e) begin
                chk("gn_nonce0", gn0, exp_q[0][63:32]);
                chk("gn_nonce3", gn3, exp_q[0][31:0]);
            end
            chk("hit_count0", hc0, m_hits);
            chk("hit_count3", hc3, m_hits);
            chk("overflow0", {31'b0, of0}, {31'b0, m_ovf});
            chk("overflow3", {31'b0, of3}, {31'b0, m_ovf});
            if (gv0 && gn_ready && e) void'(exp_q.pop_front());
        end
    end

    task automatic cyc(input logic wl, input logic [31:0] ns, input logic [255:0] tg,
                       input logic hv, input logic [255:0] h);
        work_load = wl; nonce_start = ns; target = tg; hash_valid = hv; hash = h;
        @(posedge clk); #1;
        work_load = 1'b0; hash_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] ns, input logic [255:0] tg);
        cyc(1'b1, ns, tg, 1'b0, '0);
    endtask

    task automatic beat(input logic [255:0] h);
        cyc(1'b0, 32'h0, '0, 1'b1, h);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gn_valid"}, {31'b0, gv0 | gv3}, 32'h0);
        chk({tag, "_gn_nonce0"}, gn0, 32'h0);
        chk({tag, "_gn_nonce3"}, gn3, 32'h0);
        chk({tag, "_hit_count"}, hc0 | hc3, 32'h0);
        chk({tag, "_overflow"}, {31'b0, of0 | of3}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gn_ready = 1'b1;

        // Equality passes; H7 is compared after its byte swap.
        load(32'h1000, T_EQ);
        beat(mk(32'h0, 32'hFFFF_FFFF));
        idle(4);
        beat(mk(32'h0100_0000, 32'h0));
        beat(mk(32'h0, 32'h0));
        idle(4);

        // Offset subtraction and wrap below zero.
        load(32'h1, T_EQ);
        repeat (4) beat(mk(32'h0100_0000, 32'h0));
        beat(mk(32'h0, 32'h0));
        idle(4);
        load(32'h0, T_EQ);
        beat(mk(32'h0, 32'h0));
        idle(4);

        // Full FIFO with a pop in the same cycle as a push: nothing dropped.
        gn_ready = 1'b0;
        load(32'h3000, T_ALL);
        repeat (5) beat(rand256());
        gn_ready = 1'b1;
        idle(8);

        // work_load with a beat in the same cycle; an in-flight beat keeps its old target.
        cyc(1'b1, 32'h5000, T_EQ, 1'b1, mk(32'h0100_0000, 32'h0));
        cyc(1'b1, 32'h6000, T_EQ, 1'b1, mk(32'h0, 32'h0));
        load(32'h7000, T_ALL);
        beat(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF));
        load(32'h8000, '0);
        idle(5);

        // Overflow: six golden beats into a stalled four-entry FIFO, then drain.
        gn_ready = 1'b0;
        load(32'h2000, T_ALL);
        repeat (6) beat(rand256());
        idle(4);
        chk("overflow_sticky", {31'b0, of0}, 32'h1);
        gn_ready = 1'b1;
        idle(8);

        // Random traffic, targets and backpressure.
        repeat (400) begin
            gn_ready = ($urandom_range(0, 9) < 7);
            cyc(($urandom_range(0, 19) == 0), $urandom(), rand256(),
                ($urandom_range(0, 9) < 6), rand256());
        end
        gn_ready = 1'b1;
        idle(10);

        // Reset with entries pending and beats in flight.
        gn_ready = 1'b0;
        load(32'h9000, T_ALL);
        repeat (3) beat(rand256());
        rst_n = 1'b0;
        @(negedge clk);
        reset_checks("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gn_ready = 1'b1;
        load(32'hA000, T_ALL);
        beat(rand256());
        idle(6);

        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
